spi_flash_arbiter: RTL and testbench
====================================

// Module: spi_flash_arbiter
// PURPOSE
// - Shares the single SPI flash between instruction fetch (16-bit) and data read (8-bit) requesters.
// - Arbitrates round-robin, then runs one complete SPI mode-0 read transaction per grant.
// - Sits between the fetch/PC path, the load path and the uio[0:3] SPI pins.
// PARAMETERS
// - ADDR_W       16  requester byte-address width; zero-extended to the 24-bit flash address
// - CLK_DIV      2   clk cycles per SCLK half-period (>=1); one bit = 2*CLK_DIV cycles
// - CS_HIGH_CYC  4   minimum clk cycles spi_cs stays high between transactions (>=1)
// PORTS
// - clk          in   1       system clock
// - rst          in   1       synchronous reset, active-high
// - if_req       in   1       instruction fetch request; held high, address stable, until if_ready
// - if_addr      in   ADDR_W  fetch byte address
// - if_ready     out  1       one-cycle pulse; if_data valid in that cycle
// - if_data      out  16      fetched instruction; first flash byte in [15:8]
// - dr_req       in   1       data read request; same handshake as if_req
// - dr_addr      in   ADDR_W  data byte address
// - dr_ready     out  1       one-cycle pulse; dr_data valid in that cycle
// - dr_data      out  8       read byte
// - busy         out  1       high in every state except IDLE
// - spi_cs       out  1       flash chip select, active-low
// - spi_sclk     out  1       SPI clock, idle low
// - spi_io0_o    out  1       MOSI
// - spi_io0_oe   out  1       MOSI drive enable
// - spi_io1_i    in   1       MISO
// BEHAVIOUR
// - Reset: state IDLE, spi_cs=1, spi_sclk=0, spi_io0_o=0, spi_io0_oe=0, if_ready=dr_ready=0,
//   if_data=0, dr_data=0, busy=0, last_grant=DR (so fetch wins the first tie).
// - FSM: IDLE -> CMD(8b) -> ADDR(24b) -> [DUMMY(8 clk), FAST only] -> DATA(16b fetch / 8b data) -> GAP -> IDLE.
// - IDLE: a request sampled high at cycle T0 is granted. If both are high, grant the one not granted last.
//   Otherwise grant whichever is high. Grant, address and length are latched at T0. spi_cs=0 from T0+1.
// - Bit timing: each bit is a low half then a high half, CLK_DIV cycles each. The MSB is driven at the
//   start of the low half. MISO is sampled on the cycle SCLK rises. MSB first. spi_io0_oe=1 in CMD and
//   ADDR only; 0 in DUMMY, DATA, GAP and IDLE. spi_io0_o=0 whenever oe=0.
// - Completion: let N = total bits. At T0+1+N*2*CLK_DIV the matching *_ready pulses for one cycle and
//   its *_data updates. In that same cycle spi_cs=1 and spi_sclk=0. The non-granted data output holds its value.
// - GAP: spi_cs held high for CS_HIGH_CYC cycles. Requests are ignored during GAP. The arbiter returns to
//   IDLE and re-arbitrates on the next cycle.
// - A requester must drop req the cycle after its ready. Req sampled high again in IDLE starts a new transaction.
// - A req deasserted mid-transaction does not abort it. The transaction completes and ready still pulses.
// - Address bits above ADDR_W are sent as 0. No wrap logic: the flash sequences addresses.
// - rst mid-transaction: all outputs return to reset values on the next edge. No ready is produced.
// CONFIGURATION
// - FAST_READ_EN defined: opcode 0x0B, then 8 dummy SCLK cycles after ADDR (MOSI undriven).
//   N = 56 fetch / 48 data.
// - FAST_READ_EN undefined: opcode 0x03, no DUMMY state. N = 48 fetch / 40 data.
// TESTING (CLK_DIV=2, CS_HIGH_CYC=4, flash behavioural model on the SPI pins)
// - Fetch only: if_addr=0x0012, flash bytes 0xA5,0x5A -> MOSI 03 00 00 12. if_data=0xA55A.
//   if_ready at T0+193, or T0+225 with FAST_READ_EN.
// - Data only: dr_addr=0x1FFF, flash byte 0x3C -> MOSI 03 00 1F FF. dr_data=0x3C. dr_ready at T0+161.
//   if_data is unchanged.
// - Tie after reset: if_req and dr_req rise together -> fetch served first. cs high >=4 cycles.
//   Then data is served. The next tie is also served in fetch, data order.
// - Back-to-back fetches: if_req re-asserted the cycle after if_ready -> granted on the first IDLE cycle
//   after GAP. cs never high fewer than 4 cycles.
// - Early drop: dr_req falls 10 cycles after grant -> full 40-bit transaction. dr_ready still pulses once.
// - Reset mid-ADDR: rst high for 1 cycle -> next edge cs=1, sclk=0, oe=0, busy=0. No ready pulse.
//   A new request then works normally.

Source files
------------

// File: rtl/spi_flash_arbiter.sv
// Purpose : shares one SPI flash between a 16-bit instruction-fetch requester and an 8-bit data-read
//           requester. Round-robin grant, then one complete SPI mode-0 read transaction per grant.
// Latency : ready pulses N*2*CLK_DIV+1 cycles after the grant cycle (N = 48/40 bits, 56/48 with FAST_READ_EN).
// Backpressure: req/ready handshake. Requests are held until ready. Requests are ignored while busy.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request (held until if_ready), byte address
//   if_ready/if_data         one-cycle completion pulse; 16-bit result, first flash byte in [15:8]
//   dr_req/dr_addr           data-read request (same handshake), byte address
//   dr_ready/dr_data         one-cycle completion pulse; 8-bit result
//   busy                     high whenever the FSM is not idle
//   spi_cs/spi_sclk          chip select (active-low), SPI clock (idle low)
//   spi_io0_o/spi_io0_oe     MOSI and its drive enable (driven during command and address only)
//   spi_io1_i                MISO
// Build option: define FAST_READ_EN for opcode 0x0B with 8 dummy SCLK cycles after the address.
//   When it is undefined, plain READ 0x03 is used.

module spi_flash_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int CLK_DIV     = 2,
    parameter int CS_HIGH_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [15:0]       if_data,
    input  logic              dr_req,
    input  logic [ADDR_W-1:0] dr_addr,
    output logic              dr_ready,
    output logic [7:0]        dr_data,
    output logic              busy,
    output logic              spi_cs,
    output logic              spi_sclk,
    output logic              spi_io0_o,
    output logic              spi_io0_oe,
    input  logic              spi_io1_i
);

`ifdef FAST_READ_EN
    localparam logic [7:0] OPCODE    = 8'h0B;
    localparam bit         HAS_DUMMY = 1'b1;
`else
    localparam logic [7:0] OPCODE    = 8'h03;
    localparam bit         HAS_DUMMY = 1'b0;
`endif

    localparam int CYC_W = $clog2(2 * CLK_DIV);
    localparam int GAP_W = $clog2(CS_HIGH_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;          // position inside the current bit
    logic [4:0]        bit_q, bit_d;          // bit index inside the current phase
    logic [4:0]        last_bit;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [31:0]       tx_q, tx_d;            // {opcode, 24-bit address}, MSB on the wire
    logic [15:0]       rx_q, rx_d, rx_shift;
    logic              fetch_q, fetch_d;      // current grant belongs to fetch
    logic              last_if_q, last_if_d;  // most recent grant went to fetch
    logic              grant_if;
    logic              cs_q, cs_d, sclk_q, sclk_d, oe_q, oe_d, busy_q, busy_d;
    logic              if_rdy_q, if_rdy_d, dr_rdy_q, dr_rdy_d;
    logic [15:0]       if_data_q, if_data_d;
    logic [7:0]        dr_data_q, dr_data_d;

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        bit_d     = bit_q;
        gap_d     = gap_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        fetch_d   = fetch_q;
        last_if_d = last_if_q;
        cs_d      = cs_q;
        sclk_d    = sclk_q;
        oe_d      = oe_q;
        if_rdy_d  = 1'b0;
        dr_rdy_d  = 1'b0;
        if_data_d = if_data_q;
        dr_data_d = dr_data_q;
        grant_if  = 1'b0;
        rx_shift  = rx_q;

        case (state_q)
            S_CMD:   last_bit = 5'd7;
            S_ADDR:  last_bit = 5'd23;
            S_DUMMY: last_bit = 5'd7;
            S_DATA:  last_bit = fetch_q ? 5'd15 : 5'd7;
            default: last_bit = 5'd0;
        endcase

        // MISO is captured in the first cycle of the SCLK high half.
        if (state_q == S_DATA && cyc_q == CYC_W'(CLK_DIV)) begin
            rx_shift = {rx_q[14:0], spi_io1_i};
        end

        case (state_q)
            S_IDLE: begin
                if (if_req || dr_req) begin
                    // On a tie, fetch wins unless it was the previous winner.
                    grant_if  = if_req && (!dr_req || !last_if_q);
                    fetch_d   = grant_if;
                    last_if_d = grant_if;
                    tx_d      = {OPCODE, 24'(grant_if ? if_addr : dr_addr)};
                    cyc_d     = '0;
                    bit_d     = '0;
                    rx_d      = '0;
                    cs_d      = 1'b0;
                    sclk_d    = 1'b0;
                    oe_d      = 1'b1;
                    state_d   = S_CMD;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(CS_HIGH_CYC - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                rx_d = rx_shift;
                if (cyc_q == CYC_W'(2 * CLK_DIV - 1)) begin
                    // Bit boundary: SCLK falls and the next MOSI bit is presented.
                    cyc_d  = '0;
                    sclk_d = 1'b0;
                    tx_d   = {tx_q[30:0], 1'b0};
                    if (bit_q == last_bit) begin
                        bit_d = '0;
                        case (state_q)
                            S_CMD:   state_d = S_ADDR;
                            S_ADDR:  state_d = HAS_DUMMY ? S_DUMMY : S_DATA;
                            S_DUMMY: state_d = S_DATA;
                            default: state_d = S_GAP;
                        endcase
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                    oe_d = (state_d == S_CMD) || (state_d == S_ADDR);
                    if (state_d == S_GAP) begin
                        cs_d  = 1'b1;
                        gap_d = '0;
                        if (fetch_q) begin
                            if_rdy_d  = 1'b1;
                            if_data_d = rx_shift;
                        end else begin
                            dr_rdy_d  = 1'b1;
                            dr_data_d = rx_shift[7:0];
                        end
                    end
                end else begin
                    cyc_d  = cyc_q + 1'b1;
                    sclk_d = (cyc_q >= CYC_W'(CLK_DIV - 1));
                end
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cyc_q     <= '0;
            bit_q     <= '0;
            gap_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            fetch_q   <= 1'b0;
            last_if_q <= 1'b0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            if_rdy_q  <= 1'b0;
            dr_rdy_q  <= 1'b0;
            if_data_q <= '0;
            dr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bit_q     <= bit_d;
            gap_q     <= gap_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            fetch_q   <= fetch_d;
            last_if_q <= last_if_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            if_rdy_q  <= if_rdy_d;
            dr_rdy_q  <= dr_rdy_d;
            if_data_q <= if_data_d;
            dr_data_q <= dr_data_d;
        end
    end

    assign if_ready   = if_rdy_q;
    assign if_data    = if_data_q;
    assign dr_ready   = dr_rdy_q;
    assign dr_data    = dr_data_q;
    assign busy       = busy_q;
    assign spi_cs     = cs_q;
    assign spi_sclk   = sclk_q;
    assign spi_io0_oe = oe_q;
    // Gated by the enable so MOSI rests at 0 whenever it is not driven.
    assign spi_io0_o  = oe_q & tx_q[31];

endmodule

// File: tb/tb_spi_flash_arbiter.sv
module tb_spi_flash_arbiter;
`ifdef FAST_READ_EN
    localparam int         DUMMY   = 8;
    localparam logic [7:0] OPC     = 8'h0B;
    localparam int         LAT_IF  = 225;
    localparam int         LAT_DR  = 193;
    localparam int         TIE_DR  = 422;   // 225 + 4 gap + 193
    localparam int         B2B_IF2 = 454;   // 225 + 4 gap + 225
`else
    localparam int         DUMMY   = 0;
    localparam logic [7:0] OPC     = 8'h03;
    localparam int         LAT_IF  = 193;
    localparam int         LAT_DR  = 161;
    localparam int         TIE_DR  = 358;   // 193 + 4 gap + 161
    localparam int         B2B_IF2 = 390;   // 193 + 4 gap + 193
`endif
    localparam int N_IF = 48 + DUMMY;
    localparam int N_DR = 40 + DUMMY;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, dr_req = 1'b0;
    logic [15:0] if_addr = '0, dr_addr = '0;
    logic        if_ready, dr_ready, busy, spi_cs, spi_sclk, spi_io0_o, spi_io0_oe;
    logic [15:0] if_data;
    logic [7:0]  dr_data;
    logic        spi_io1_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // flash model state
    int          fl_bits = 0;
    int          fl_err  = 0;
    logic [7:0]  fl_cmd  = '0;
    logic [23:0] fl_addr = '0;
    // values captured at each completion
    int          proto_err = 0;
    logic [7:0]  cap_cmd;
    logic [23:0] cap_addr;
    int          cap_bits;

    spi_flash_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
        .dr_req(dr_req), .dr_addr(dr_addr), .dr_ready(dr_ready), .dr_data(dr_data),
        .busy(busy), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
        .spi_io0_o(spi_io0_o), .spi_io0_oe(spi_io0_oe), .spi_io1_i(spi_io1_i)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h000012: flash_byte = 8'hA5;
            24'h000013: flash_byte = 8'h5A;
            24'h001FFF: flash_byte = 8'h3C;
            24'h000055: flash_byte = 8'h81;
            24'h000100: flash_byte = 8'hDE;
            24'h000101: flash_byte = 8'hAD;
            24'h000102: flash_byte = 8'hBE;
            24'h000103: flash_byte = 8'hEF;
            default:    flash_byte = a[7:0] ^ 8'hC3;
        endcase
    endfunction

    // Flash receive side: counters clear when CS falls (SCLK is low then); MOSI captured on SCLK rise.
    always @(posedge spi_sclk or negedge spi_cs) begin
        if (!spi_sclk) begin
            fl_bits = 0;
            fl_cmd  = '0;
            fl_addr = '0;
        end else if (!spi_cs) begin
            if (spi_io0_oe !== (fl_bits < 32)) fl_err++;
            if (!spi_io0_oe && spi_io0_o !== 1'b0) fl_err++;
            if (fl_bits < 8) fl_cmd = {fl_cmd[6:0], spi_io0_o};
            else if (fl_bits < 32) fl_addr = {fl_addr[22:0], spi_io0_o};
            fl_bits++;
        end
    end

    // Flash transmit side: next data bit presented on SCLK fall.
    always @(negedge spi_sclk) begin
        if (!spi_cs && fl_bits >= 32 + DUMMY) begin
            int d;
            logic [7:0] b;
            d = fl_bits - 32 - DUMMY;
            b = flash_byte(fl_addr + 24'(d / 8));
            spi_io1_i = b[7 - (d % 8)];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives up to two fetches and one data read, called right after a negedge.
    task automatic serve(input int n_if, input int n_dr, input logic [15:0] ia1, input logic [15:0] ia2,
                         input logic [15:0] da, input int drop_dr_at,
                         output int t_if1, output int t_if2, output int t_dr, output int min_gap,
                         output int n_if_rdy, output int n_dr_rdy,
                         output logic [15:0] if_d1, output logic [15:0] if_d2, output logic [7:0] dr_d);
        int cyc = 0, if_left = n_if, dr_left = n_dr, run = 0;
        bit seen_low = 0, reraise = 0;
        t_if1 = -1; t_if2 = -1; t_dr = -1; min_gap = 1000; n_if_rdy = 0; n_dr_rdy = 0;
        if_d1 = 'x; if_d2 = 'x; dr_d = 'x;
        if_addr = ia1; dr_addr = da;
        if_req = (n_if > 0); dr_req = (n_dr > 0);
        while ((if_left > 0 || dr_left > 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (spi_cs) run++;
            else begin
                if (seen_low && run > 0 && run < min_gap) min_gap = run;
                run = 0; seen_low = 1;
                if (!busy) proto_err++;
            end
            if (spi_cs && spi_sclk) proto_err++;
            if (reraise) begin if_req = 1'b1; if_addr = ia2; reraise = 0; end
            if (if_ready) begin
                n_if_rdy++; if_left--;
                if (t_if1 < 0) begin t_if1 = cyc; if_d1 = if_data; end
                else begin t_if2 = cyc; if_d2 = if_data; end
                cap_cmd = fl_cmd; cap_addr = fl_addr; cap_bits = fl_bits;
                if (!spi_cs || spi_sclk) proto_err++;
                if_req = 1'b0;
                if (if_left > 0) reraise = 1;
            end
            if (dr_ready) begin
                n_dr_rdy++; dr_left--; t_dr = cyc; dr_d = dr_data;
                cap_cmd = fl_cmd; cap_addr = fl_addr; cap_bits = fl_bits;
                if (!spi_cs || spi_sclk) proto_err++;
                dr_req = 1'b0;
            end
            if (drop_dr_at > 0 && cyc == drop_dr_at) dr_req = 1'b0;
        end
        if_req = 1'b0; dr_req = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (if_ready) n_if_rdy++;
            if (dr_ready) n_dr_rdy++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (spi_cs !== 1'b1)     begin n_fail++; $display("FAIL reset_cs: got %b want 1", spi_cs); end
        n_checks++; if (spi_sclk !== 1'b0)   begin n_fail++; $display("FAIL reset_sclk: got %b want 0", spi_sclk); end
        n_checks++; if (spi_io0_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", spi_io0_oe); end
        n_checks++; if (spi_io0_o !== 1'b0)  begin n_fail++; $display("FAIL reset_mosi: got %b want 0", spi_io0_o); end
        n_checks++; if (if_ready !== 1'b0)   begin n_fail++; $display("FAIL reset_if_ready: got %b want 0", if_ready); end
        n_checks++; if (dr_ready !== 1'b0)   begin n_fail++; $display("FAIL reset_dr_ready: got %b want 0", dr_ready); end
        n_checks++; if (if_data !== 16'h0)   begin n_fail++; $display("FAIL reset_if_data: got %h want 0000", if_data); end
        n_checks++; if (dr_data !== 8'h0)    begin n_fail++; $display("FAIL reset_dr_data: got %h want 00", dr_data); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        int t1, t2, td, mg, ni, nd; logic [15:0] d1, d2; logic [7:0] dd;
        serve(1, 0, 16'h0012, 16'h0, 16'h0, 0, t1, t2, td, mg, ni, nd, d1, d2, dd);
        n_checks++; if (t1 !== LAT_IF)         begin n_fail++; $display("FAIL fetch_latency: got %0d want %0d", t1, LAT_IF); end
        n_checks++; if (d1 !== 16'hA55A)       begin n_fail++; $display("FAIL fetch_data: got %h want a55a", d1); end
        n_checks++; if (cap_cmd !== OPC)       begin n_fail++; $display("FAIL fetch_opcode: got %h want %h", cap_cmd, OPC); end
        n_checks++; if (cap_addr !== 24'h12)   begin n_fail++; $display("FAIL fetch_addr: got %h want 000012", cap_addr); end
        n_checks++; if (cap_bits !== N_IF)     begin n_fail++; $display("FAIL fetch_bits: got %0d want %0d", cap_bits, N_IF); end
        n_checks++; if (ni !== 1 || nd !== 0)  begin n_fail++; $display("FAIL fetch_ready_count: got if=%0d dr=%0d want 1/0", ni, nd); end
        n_checks++; if (dr_data !== 8'h00)     begin n_fail++; $display("FAIL fetch_dr_hold: got %h want 00", dr_data); end
        n_checks++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL fetch_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_data();
        int t1, t2, td, mg, ni, nd; logic [15:0] d1, d2; logic [7:0] dd;
        serve(0, 1, 16'h0, 16'h0, 16'h1FFF, 0, t1, t2, td, mg, ni, nd, d1, d2, dd);
        n_checks++; if (td !== LAT_DR)           begin n_fail++; $display("FAIL data_latency: got %0d want %0d", td, LAT_DR); end
        n_checks++; if (dd !== 8'h3C)            begin n_fail++; $display("FAIL data_value: got %h want 3c", dd); end
        n_checks++; if (cap_addr !== 24'h001FFF) begin n_fail++; $display("FAIL data_addr: got %h want 001fff", cap_addr); end
        n_checks++; if (cap_bits !== N_DR)       begin n_fail++; $display("FAIL data_bits: got %0d want %0d", cap_bits, N_DR); end
        n_checks++; if (if_data !== 16'hA55A)    begin n_fail++; $display("FAIL data_if_hold: got %h want a55a", if_data); end
        n_checks++; if (ni !== 0 || nd !== 1)    begin n_fail++; $display("FAIL data_ready_count: got if=%0d dr=%0d want 0/1", ni, nd); end
    endtask

    task automatic test_tie();
        int t1, t2, td, mg, ni, nd; logic [15:0] d1, d2; logic [7:0] dd;
        pulse_reset();
        for (int round = 0; round < 2; round++) begin
            serve(1, 1, 16'h0012, 16'h0, 16'h1FFF, 0, t1, t2, td, mg, ni, nd, d1, d2, dd);
            n_checks++; if (t1 !== LAT_IF)   begin n_fail++; $display("FAIL tie%0d_fetch_first: got %0d want %0d", round, t1, LAT_IF); end
            n_checks++; if (td !== TIE_DR)   begin n_fail++; $display("FAIL tie%0d_data_second: got %0d want %0d", round, td, TIE_DR); end
            n_checks++; if (mg < 4)          begin n_fail++; $display("FAIL tie%0d_cs_gap: got %0d want >=4", round, mg); end
            n_checks++; if (d1 !== 16'hA55A || dd !== 8'h3C)
                begin n_fail++; $display("FAIL tie%0d_values: got %h/%h want a55a/3c", round, d1, dd); end
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2, td, mg, ni, nd; logic [15:0] d1, d2; logic [7:0] dd;
        serve(2, 0, 16'h0100, 16'h0102, 16'h0, 0, t1, t2, td, mg, ni, nd, d1, d2, dd);
        n_checks++; if (t1 !== LAT_IF)   begin n_fail++; $display("FAIL b2b_first: got %0d want %0d", t1, LAT_IF); end
        n_checks++; if (t2 !== B2B_IF2)  begin n_fail++; $display("FAIL b2b_second: got %0d want %0d", t2, B2B_IF2); end
        n_checks++; if (d1 !== 16'hDEAD) begin n_fail++; $display("FAIL b2b_data1: got %h want dead", d1); end
        n_checks++; if (d2 !== 16'hBEEF) begin n_fail++; $display("FAIL b2b_data2: got %h want beef", d2); end
        n_checks++; if (mg < 4)          begin n_fail++; $display("FAIL b2b_cs_gap: got %0d want >=4", mg); end
        n_checks++; if (ni !== 2)        begin n_fail++; $display("FAIL b2b_ready_count: got %0d want 2", ni); end
    endtask

    task automatic test_early_drop();
        int t1, t2, td, mg, ni, nd; logic [15:0] d1, d2; logic [7:0] dd;
        serve(0, 1, 16'h0, 16'h0, 16'h0055, 10, t1, t2, td, mg, ni, nd, d1, d2, dd);
        n_checks++; if (td !== LAT_DR)     begin n_fail++; $display("FAIL drop_latency: got %0d want %0d", td, LAT_DR); end
        n_checks++; if (dd !== 8'h81)      begin n_fail++; $display("FAIL drop_data: got %h want 81", dd); end
        n_checks++; if (nd !== 1)          begin n_fail++; $display("FAIL drop_ready_count: got %0d want 1", nd); end
        n_checks++; if (cap_bits !== N_DR) begin n_fail++; $display("FAIL drop_bits: got %0d want %0d", cap_bits, N_DR); end
    endtask

    task automatic test_reset_mid_addr();
        int t1, t2, td, mg, ni, nd, extra; logic [15:0] d1, d2; logic [7:0] dd;
        if_addr = 16'h0012; if_req = 1'b1;
        repeat (50) @(negedge clk);
        n_checks++; if (spi_io0_oe !== 1'b1 || spi_cs !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_in_addr: got oe=%b cs=%b want 1/0", spi_io0_oe, spi_cs); end
        rst = 1'b1; if_req = 1'b0;
        @(negedge clk);
        n_checks++; if (spi_cs !== 1'b1)     begin n_fail++; $display("FAIL rstmid_cs: got %b want 1", spi_cs); end
        n_checks++; if (spi_sclk !== 1'b0)   begin n_fail++; $display("FAIL rstmid_sclk: got %b want 0", spi_sclk); end
        n_checks++; if (spi_io0_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_oe: got %b want 0", spi_io0_oe); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_checks++; if (if_data !== 16'h0)   begin n_fail++; $display("FAIL rstmid_if_data: got %h want 0000", if_data); end
        rst = 1'b0;
        extra = 0;
        repeat (250) begin
            @(negedge clk);
            if (if_ready || dr_ready) extra++;
        end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL rstmid_no_ready: got %0d pulses want 0", extra); end
        serve(0, 1, 16'h0, 16'h0, 16'h1FFF, 0, t1, t2, td, mg, ni, nd, d1, d2, dd);
        n_checks++; if (td !== LAT_DR || dd !== 8'h3C)
            begin n_fail++; $display("FAIL rstmid_recover: got t=%0d d=%h want %0d/3c", td, dd, LAT_DR); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_data();
        test_tie();
        test_back_to_back();
        test_early_drop();
        test_reset_mid_addr();
        n_checks++; if (fl_err !== 0)    begin n_fail++; $display("FAIL mosi_oe_protocol: got %0d violations want 0", fl_err); end
        n_checks++; if (proto_err !== 0) begin n_fail++; $display("FAIL cs_sclk_busy_protocol: got %0d violations want 0", proto_err); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
